demux_stream_router: RTL

- Parametrised, registered successor to the combinational 1-to-8 demux: routes a valid/ready input stream to one of NUM_CH output channels, or to all channels in broadcast mode.
- Routing is packet-based: the select is sampled on the first beat of a packet and held until the last beat is accepted.
- Each channel has a one-entry output register with independent backpressure.
- Sits between a single producer and NUM_CH consumer lanes.

---
 rtl/demux_stream_router.sv | 115 +++++++++++
 1 files changed

// File: rtl/demux_stream_router.sv
// Packet-based valid/ready router: one input stream to NUM_CH registered output
// slots, with per-packet route locking, atomic broadcast and out-of-range drop.
module demux_stream_router #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned SEL_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     bcast,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_last,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [15:0]              drop_cnt
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                    state_q, state_d;
    logic [NUM_CH-1:0]         route_q, route_d;
    logic [NUM_CH-1:0]         valid_q, valid_d;
    logic [NUM_CH-1:0]         last_q, last_d;
    logic [NUM_CH*DATA_W-1:0]  data_q, data_d;
    logic [15:0]               drop_cnt_q, drop_cnt_d;

    logic [NUM_CH-1:0]         live_mask;
    logic [NUM_CH-1:0]         target;
    logic [NUM_CH-1:0]         slot_free;
    logic                      drop_mode;
    logic                      accept;

    // An out-of-range sel matches no channel, which yields the empty drop mask.
    always_comb begin
        live_mask = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            live_mask[k] = bcast || (sel == SEL_W'(k));
        end
    end

    always_comb begin
        target    = (state_q == LOCKED) ? route_q : live_mask;
        drop_mode = ~|target;
        slot_free = ~valid_q | out_ready;
        in_ready  = drop_mode || (&(slot_free | ~target));
        accept    = in_valid && in_ready;
    end

    always_comb begin
        state_d = state_q;
        route_d = route_q;
        case (state_q)
            IDLE: begin
                if (accept && !in_last) begin
                    state_d = LOCKED;
                    route_d = live_mask;
                end
            end
            LOCKED: begin
                if (accept && in_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d    = valid_q;
        last_d     = last_q;
        data_d     = data_q;
        drop_cnt_d = drop_cnt_q;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (accept && target[k]) begin
                valid_d[k]                   = 1'b1;
                last_d[k]                    = in_last;
                data_d[k*DATA_W +: DATA_W]   = in_data;
            end else if (out_ready[k]) begin
                valid_d[k] = 1'b0;
            end
        end
        if (accept && drop_mode && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            route_q    <= '0;
            valid_q    <= '0;
            last_q     <= '0;
            data_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            route_q    <= route_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            data_q     <= data_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_data  = data_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
